// File: rtl/rtp_ray_batch_scheduler.sv
// Batch sequencer for one RTP traversal: loads rays into the RTP ray memories,
// kicks the RTP, buffers its hit results and hands them to a downstream consumer.
module rtp_ray_batch_scheduler #(
    parameter int unsigned MAX_RAYS = 64,
    parameter int unsigned CNT_W    = 7,
    parameter int unsigned TIMEOUT  = 1048576
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ray_valid,
    output logic        ray_ready,
    input  logic [95:0] ray_o,
    input  logic [95:0] ray_d,
    input  logic [95:0] ray_idir,
    input  logic [95:0] ray_ood,
    input  logic        ray_last,
    output logic [95:0] o_wrData,
    output logic [95:0] d_wrData,
    output logic [95:0] idir_wrData,
    output logic [95:0] ood_wrData,
    output logic [31:0] ray_wrAddr,
    output logic        ray_wrEn,
    output logic        rtp_start,
    output logic [31:0] rtp_ray_count,
    input  logic        rtp_finish,
    input  logic        res_in_valid,
    input  logic [31:0] res_in_id,
    input  logic [31:0] res_in_hitT,
    input  logic [31:0] res_in_hitIndex,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_id,
    output logic [31:0] res_hitT,
    output logic [31:0] res_hitIndex,
    output logic        busy,
    output logic        batch_done,
    output logic        timeout_err,
    output logic        extra_result_err
);
    localparam int unsigned PTR_W = $clog2(MAX_RAYS);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_RAYS);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN} stateT;

    stateT            state;
    logic [CNT_W-1:0] sentCnt;
    logic [CNT_W-1:0] rcvCnt;
    logic [CNT_W-1:0] fifoCount;
    logic [TO_W-1:0]  toCnt;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [95:0]      fifoMem [MAX_RAYS];
    logic             timeoutErrQ;
    logic             extraErrQ;

    logic             rayAccept;
    logic             captureActive;
    logic             fifoFull;
    logic             pop;
    logic             push;
    logic             drop;
    logic             doneNow;
    logic [CNT_W-1:0] baseCnt;
    logic [CNT_W-1:0] nextSent;
    logic [CNT_W-1:0] rcvBase;
    logic [95:0]      headWord;

    // A new batch always starts writing at address 0; the result counter restarts in START.
    assign baseCnt  = (state == IDLE) ? '0 : sentCnt;
    assign nextSent = baseCnt + CNT_W'(1);
    assign rcvBase  = (state == START) ? '0 : rcvCnt;

    // Zero-latency ray write path; ready is held low while reset is asserted.
    assign ray_ready   = reset && ((state == IDLE) || ((state == LOAD) && (sentCnt < MAX_CNT)));
    assign rayAccept   = ray_valid && ray_ready;
    assign ray_wrEn    = rayAccept;
    assign ray_wrAddr  = rayAccept ? 32'(baseCnt) : '0;
    assign o_wrData    = rayAccept ? ray_o    : '0;
    assign d_wrData    = rayAccept ? ray_d    : '0;
    assign idir_wrData = rayAccept ? ray_idir : '0;
    assign ood_wrData  = rayAccept ? ray_ood  : '0;

    // Result FIFO control; a pop on a full FIFO makes room for a same-cycle push.
    assign captureActive = (state == START) || (state == RUN) || (state == DRAIN);
    assign fifoFull      = (fifoCount == MAX_CNT);
    assign pop           = (fifoCount != '0) && res_ready;
    assign push          = captureActive && res_in_valid && (rcvBase < sentCnt) && (!fifoFull || pop);
    assign drop          = captureActive && res_in_valid && !push;
    assign headWord      = fifoMem[rdPtr];

    assign doneNow = (state == DRAIN) && (fifoCount == '0) && ((rcvCnt == sentCnt) || timeoutErrQ);

    assign res_valid        = (fifoCount != '0);
    assign res_id           = res_valid ? headWord[95:64] : '0;
    assign res_hitT         = res_valid ? headWord[63:32] : '0;
    assign res_hitIndex     = res_valid ? headWord[31:0]  : '0;
    assign rtp_start        = (state == START);
    assign rtp_ray_count    = ((state == START) || (state == RUN) || (state == DRAIN)) ? 32'(sentCnt) : '0;
    assign busy             = (state != IDLE);
    assign batch_done       = doneNow;
    assign timeout_err      = timeoutErrQ;
    assign extra_result_err = extraErrQ;

    // Batch sequencing, counters, FIFO pointers and sticky error flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            sentCnt     <= '0;
            rcvCnt      <= '0;
            fifoCount   <= '0;
            toCnt       <= '0;
            wrPtr       <= '0;
            rdPtr       <= '0;
            timeoutErrQ <= 1'b0;
            extraErrQ   <= 1'b0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (rayAccept) begin
                        sentCnt <= nextSent;
                        state   <= (ray_last || (nextSent == MAX_CNT)) ? START : LOAD;
                    end
                end
                START: begin
                    toCnt <= '0;
                    state <= RUN;
                end
                RUN: begin
                    toCnt <= toCnt + TO_W'(1);
                    if (rtp_finish) begin
                        state <= DRAIN;
                    end else if ((toCnt + TO_W'(1)) == TO_LIMIT) begin
                        timeoutErrQ <= 1'b1;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (doneNow) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push || (state == START)) begin
                rcvCnt <= rcvBase + (push ? CNT_W'(1) : CNT_W'(0));
            end
            if (drop) begin
                extraErrQ <= 1'b1;
            end
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + CNT_W'(1);
                2'b01:   fifoCount <= fifoCount - CNT_W'(1);
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    // Result storage; contents need no reset since the count gates visibility.
    always_ff @(posedge clock) begin
        if (push) begin
            fifoMem[wrPtr] <= {res_in_id, res_in_hitT, res_in_hitIndex};
        end
    end

endmodule

// File: tb/tb_rtp_ray_batch_scheduler.sv
// Self-checking bench for rtp_ray_batch_scheduler: table-driven batches,
// randomized batches against a queue-based model, and hand-written corner cases.
module tb_rtp_ray_batch_scheduler;
    logic        clock = 1'b0;
    logic        reset;
    logic        ray_valid, ray_ready, ray_last;
    logic [95:0] ray_o, ray_d, ray_idir, ray_ood;
    logic [95:0] o_wrData, d_wrData, idir_wrData, ood_wrData;
    logic [31:0] ray_wrAddr;
    logic        ray_wrEn, rtp_start, rtp_finish;
    logic [31:0] rtp_ray_count;
    logic        res_in_valid, res_valid, res_ready;
    logic [31:0] res_in_id, res_in_hitT, res_in_hitIndex;
    logic [31:0] res_id, res_hitT, res_hitIndex;
    logic        busy, batch_done, timeout_err, extra_result_err;

    rtp_ray_batch_scheduler #(.MAX_RAYS(64), .CNT_W(7), .TIMEOUT(100)) dut (
        .clock(clock), .reset(reset),
        .ray_valid(ray_valid), .ray_ready(ray_ready),
        .ray_o(ray_o), .ray_d(ray_d), .ray_idir(ray_idir), .ray_ood(ray_ood),
        .ray_last(ray_last),
        .o_wrData(o_wrData), .d_wrData(d_wrData), .idir_wrData(idir_wrData), .ood_wrData(ood_wrData),
        .ray_wrAddr(ray_wrAddr), .ray_wrEn(ray_wrEn),
        .rtp_start(rtp_start), .rtp_ray_count(rtp_ray_count), .rtp_finish(rtp_finish),
        .res_in_valid(res_in_valid), .res_in_id(res_in_id), .res_in_hitT(res_in_hitT),
        .res_in_hitIndex(res_in_hitIndex),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_hitT(res_hitT), .res_hitIndex(res_hitIndex),
        .busy(busy), .batch_done(batch_done), .timeout_err(timeout_err),
        .extra_result_err(extra_result_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [95:0] o, d, idir, ood;
    } wrT;

    typedef struct {
        int nRays;
        bit useLast;
        int vm;
        int rm;
        int expCount;
    } vecT;

    int          checks = 0;
    int          errors = 0;
    logic [95:0] rayO [80];
    logic [95:0] rayD [80];
    logic [95:0] rayI [80];
    logic [95:0] rayR [80];
    wrT          wrLog[$];
    logic [95:0] popLog[$];
    logic [95:0] expRes[$];
    int          startPulses = 0;
    int          donePulses = 0;
    int          wrEnBad = 0;
    int          feedK = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Passive monitor: logs writes and pops, counts pulses, checks strobe/handshake agreement.
    always @(negedge clock) begin
        if (ray_wrEn) wrLog.push_back('{ray_wrAddr, o_wrData, d_wrData, idir_wrData, ood_wrData});
        if (ray_wrEn !== (ray_valid && ray_ready)) wrEnBad++;
        if (res_valid && res_ready) popLog.push_back({res_id, res_hitT, res_hitIndex});
        if (rtp_start) startPulses++;
        if (batch_done) donePulses++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic readyVal(input int rm, input bit draining);
        if (rm == 0) return draining;
        if (rm == 1) return 1'b1;
        return 1'($urandom % 2);
    endfunction

    task automatic clearLogs();
        wrLog.delete(); popLog.delete(); expRes.delete();
        startPulses = 0; donePulses = 0; wrEnBad = 0;
    endtask

    task automatic fillRays();
        for (int i = 0; i < 80; i++) begin
            rayO[i] = {$urandom, $urandom, $urandom};
            rayD[i] = {$urandom, $urandom, $urandom};
            rayI[i] = {$urandom, $urandom, $urandom};
            rayR[i] = {$urandom, $urandom, $urandom};
        end
    endtask

    task automatic driveRay(input int k);
        ray_o = rayO[k]; ray_d = rayD[k]; ray_idir = rayI[k]; ray_ood = rayR[k];
    endtask

    // Offers rays until the model says the batch has ended (ray_last or 64 accepted).
    task automatic feed(input int n, input bit useLast, input int vm);
        int k = 0;
        bit ended = 0;
        int cyc = 0;
        while (!ended && cyc < 1000) begin
            @(posedge clock); #1;
            if (vm == 0)      ray_valid = 1'b1;
            else if (vm == 1) ray_valid = (cyc % 2 == 0);
            else              ray_valid = 1'($urandom % 2);
            driveRay(k);
            ray_last = useLast && (k == n - 1);
            @(negedge clock);
            if (ray_valid && ray_ready) begin
                k++;
                if (ray_last || k == 64) ended = 1;
            end
            cyc++;
        end
        if (!ended) check("feed_timeout", 128'(0), 128'(1));
        feedK = k;
    endtask

    task automatic waitStart(input int expCount);
        int found = 0;
        for (int i = 1; i <= 10 && found == 0; i++) begin
            @(posedge clock); #1;
            ray_valid = (i == 1);
            ray_last = 1'b0;
            driveRay(feedK);
            @(negedge clock);
            if (i == 1) check("ready_after_load", 128'(ray_ready), 128'(0));
            if (rtp_start) found = i;
        end
        check("start_latency", 128'(found), 128'(1));
        check("ray_count", 128'(rtp_ray_count), 128'(expCount));
        check("busy_in_start", 128'(busy), 128'(1));
    endtask

    task automatic sendResults(input int n, input int rm, input bit fin);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            ray_valid = 1'b0;
            res_in_valid = 1'b1;
            res_in_id = 32'(i);
            res_in_hitT = 32'h3F80_0000 + 32'(i);
            res_in_hitIndex = $urandom;
            res_ready = readyVal(rm, 1'b0);
            expRes.push_back({res_in_id, res_in_hitT, res_in_hitIndex});
            @(negedge clock);
        end
        @(posedge clock); #1;
        ray_valid = 1'b0;
        res_in_valid = 1'b0;
        rtp_finish = fin;
        res_ready = readyVal(rm, 1'b0);
        @(negedge clock);
    endtask

    task automatic waitDone(input int rm, input int expCount);
        int found = 0;
        for (int i = 1; i <= 400 && found == 0; i++) begin
            @(posedge clock); #1;
            rtp_finish = 1'b0;
            res_ready = readyVal(rm, 1'b1);
            @(negedge clock);
            if (batch_done) found = i;
        end
        check("done_seen", 128'(found != 0), 128'(1));
        check("fifo_empty_at_done", 128'(res_valid), 128'(0));
        check("ready_at_done", 128'(ray_ready), 128'(0));
        check("count_stable", 128'(rtp_ray_count), 128'(expCount));
        @(posedge clock); #1;
        res_ready = 1'b0;
        @(negedge clock);
        check("busy_after_done", 128'(busy), 128'(0));
        check("ready_after_done", 128'(ray_ready), 128'(1));
    endtask

    // Compares logged traffic with the expected batch: contiguous writes and in-order results.
    task automatic checkBatch(input int cnt);
        check("wr_count", 128'(wrLog.size()), 128'(cnt));
        for (int i = 0; i < wrLog.size() && i < cnt; i++) begin
            check($sformatf("wr_addr[%0d]", i), 128'(wrLog[i].addr), 128'(i));
            check($sformatf("wr_o[%0d]", i), 128'(wrLog[i].o), 128'(rayO[i]));
            check($sformatf("wr_d[%0d]", i), 128'(wrLog[i].d), 128'(rayD[i]));
            check($sformatf("wr_idir[%0d]", i), 128'(wrLog[i].idir), 128'(rayI[i]));
            check($sformatf("wr_ood[%0d]", i), 128'(wrLog[i].ood), 128'(rayR[i]));
        end
        check("res_count", 128'(popLog.size()), 128'(expRes.size()));
        for (int i = 0; i < popLog.size() && i < expRes.size(); i++)
            check($sformatf("res[%0d]", i), 128'(popLog[i]), 128'(expRes[i]));
        check("start_pulses", 128'(startPulses), 128'(1));
        check("done_pulses", 128'(donePulses), 128'(1));
        check("wren_only_on_accept", 128'(wrEnBad), 128'(0));
    endtask

    task automatic runBatch(input int n, input bit useLast, input int vm, input int rm, input int expCount);
        clearLogs();
        fillRays();
        feed(n, useLast, vm);
        waitStart(expCount);
        sendResults(expCount, rm, 1'b1);
        waitDone(rm, expCount);
        checkBatch(expCount);
    endtask

    initial begin
        vecT vecs[7];
        int  firstErr;

        vecs[0] = '{4,  1'b1, 0, 1, 4};
        vecs[1] = '{80, 1'b0, 0, 1, 64};
        vecs[2] = '{5,  1'b1, 1, 1, 5};
        vecs[3] = '{1,  1'b1, 0, 1, 1};
        vecs[4] = '{70, 1'b1, 0, 2, 64};
        vecs[5] = '{64, 1'b1, 2, 2, 64};
        vecs[6] = '{33, 1'b1, 2, 0, 33};

        reset = 1'b0; ray_valid = 1'b0; ray_last = 1'b0;
        ray_o = '0; ray_d = '0; ray_idir = '0; ray_ood = '0;
        rtp_finish = 1'b0; res_in_valid = 1'b0; res_in_id = '0; res_in_hitT = '0;
        res_in_hitIndex = '0; res_ready = 1'b0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_ray_ready", 128'(ray_ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_wren", 128'(ray_wrEn), 128'(0));
        check("rst_start", 128'(rtp_start), 128'(0));
        check("rst_count", 128'(rtp_ray_count), 128'(0));
        check("rst_res_valid", 128'(res_valid), 128'(0));
        check("rst_done", 128'(batch_done), 128'(0));
        check("rst_timeout", 128'(timeout_err), 128'(0));
        check("rst_extra", 128'(extra_result_err), 128'(0));
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("idle_ready", 128'(ray_ready), 128'(1));

        for (int v = 0; v < 7; v++)
            runBatch(vecs[v].nRays, vecs[v].useLast, vecs[v].vm, vecs[v].rm, vecs[v].expCount);

        for (int r = 0; r < 6; r++) begin
            bit useL;
            int n;
            useL = ($urandom % 4) != 0;
            n = $urandom_range(1, 64);
            runBatch(useL ? n : 80, useL, $urandom % 3, $urandom % 3, useL ? n : 64);
        end
        check("no_extra_err", 128'(extra_result_err), 128'(0));
        check("no_timeout_err", 128'(timeout_err), 128'(0));

        // Full FIFO with consumer stalled, then one spurious result.
        clearLogs();
        fillRays();
        feed(64, 1'b1, 0);
        waitStart(64);
        sendResults(64, 0, 1'b0);
        check("full_res_valid", 128'(res_valid), 128'(1));
        check("extra_before", 128'(extra_result_err), 128'(0));
        @(posedge clock); #1;
        res_in_valid = 1'b1; res_in_id = 32'd99; res_in_hitT = 32'hDEAD_BEEF; res_in_hitIndex = 32'd7;
        @(negedge clock);
        @(posedge clock); #1;
        res_in_valid = 1'b0; rtp_finish = 1'b1;
        @(negedge clock);
        check("extra_after", 128'(extra_result_err), 128'(1));
        waitDone(0, 64);
        checkBatch(64);

        // Reset during RUN with three results buffered.
        clearLogs();
        fillRays();
        feed(3, 1'b1, 0);
        waitStart(3);
        sendResults(3, 0, 1'b0);
        check("buffered_before_reset", 128'(res_valid), 128'(1));
        donePulses = 0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        @(posedge clock); #1;
        @(negedge clock);
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_res_valid", 128'(res_valid), 128'(0));
        check("midrst_ready", 128'(ray_ready), 128'(0));
        check("midrst_count", 128'(rtp_ray_count), 128'(0));
        check("midrst_extra", 128'(extra_result_err), 128'(0));
        check("midrst_res_id", 128'(res_id), 128'(0));
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("midrst_no_done", 128'(donePulses), 128'(0));
        check("midrst_idle_ready", 128'(ray_ready), 128'(1));
        runBatch(1, 1'b1, 0, 1, 1);

        // RTP never finishes: timeout raised 100 cycles after entering RUN.
        clearLogs();
        fillRays();
        feed(2, 1'b1, 0);
        waitStart(2);
        firstErr = -1;
        for (int j = 1; j <= 130 && firstErr < 0; j++) begin
            @(posedge clock); #1;
            ray_valid = 1'b0;
            res_ready = 1'b0;
            res_in_valid = (j == 1);
            if (j == 1) begin
                res_in_id = 32'd0; res_in_hitT = 32'h3F80_0000; res_in_hitIndex = $urandom;
                expRes.push_back({res_in_id, res_in_hitT, res_in_hitIndex});
            end
            @(negedge clock);
            if (timeout_err) firstErr = j;
        end
        check("timeout_cycle", 128'(firstErr), 128'(101));
        check("timeout_fifo_held", 128'(res_valid), 128'(1));
        check("timeout_busy", 128'(busy), 128'(1));
        waitDone(0, 2);
        checkBatch(2);
        check("timeout_sticky", 128'(timeout_err), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
